// File: rtl/cordic_vectoring.sv
// cordic_vectoring
//   Iterative CORDIC in vectoring mode. Takes a signed 16-bit (x, y) vector and
//   returns its gain-compensated magnitude and its angle as a 32-bit binary
//   angle (2^32 = 360 deg), the same format the rotation-mode cordic consumes.
//   One micro-rotation per clock, 16 iterations, 18 clocks per result.
//
// Handshake: start is sampled only on a rising edge where ready=1; start while
//   ready=0 is ignored (no queueing). valid is a one-cycle pulse in the cycle
//   after the COMP edge, during which ready is already high again, so a start
//   held high is accepted back-to-back. mag/angle hold until the next COMP.
//
// Ports:
//   clock    in   1   rising-edge clock
//   reset    in   1   synchronous, active-high; wins over start
//   start    in   1   request, sampled while ready=1
//   xin      in  16   signed x component
//   yin      in  16   signed y component
//   ready    out  1   idle and able to accept start
//   valid    out  1   one-cycle pulse when mag/angle update
//   mag      out 17   unsigned magnitude, input LSB units
//   angle    out 32   atan2(y, x) binary angle, [-180, 180)
//   state_o  out  2   FSM state for debug (0=IDLE, 1=ITER, 2=COMP)

module cordic_vectoring (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] xin,
    input  logic signed [15:0] yin,
    output logic               ready,
    output logic               valid,
    output logic        [16:0] mag,
    output logic        [31:0] angle,
    output logic        [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        COMP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic        [3:0]  cnt_q, cnt_d;
    logic signed [17:0] x_q, x_d;
    logic signed [17:0] y_q, y_d;
    logic        [31:0] z_q, z_d;
    logic               zero_q, zero_d;
    logic        [16:0] mag_q, mag_d;
    logic        [31:0] angle_q, angle_d;
    logic               valid_q, valid_d;

    logic signed [17:0] xs_ext, ys_ext;
    logic signed [17:0] x_sh, y_sh;
    logic        [16:0] x_mag;
    logic        [16:0] mag_sum;

    // atan(2^-i) scaled so that 2^32 = 360 degrees.
    function automatic logic [31:0] atan_lut(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0:  v = 32'h2000_0000;
            4'd1:  v = 32'h12E4_051E;
            4'd2:  v = 32'h09FB_385B;
            4'd3:  v = 32'h0511_11D4;
            4'd4:  v = 32'h028B_0D43;
            4'd5:  v = 32'h0145_D7E1;
            4'd6:  v = 32'h00A2_F61E;
            4'd7:  v = 32'h0051_7C55;
            4'd8:  v = 32'h0028_BE53;
            4'd9:  v = 32'h0014_5F2F;
            4'd10: v = 32'h000A_2F98;
            4'd11: v = 32'h0005_17CC;
            4'd12: v = 32'h0002_8BE6;
            4'd13: v = 32'h0001_45F3;
            4'd14: v = 32'h0000_A2FA;
            default: v = 32'h0000_517D;
        endcase
        return v;
    endfunction

    assign xs_ext = {{2{xin[15]}}, xin};
    assign ys_ext = {{2{yin[15]}}, yin};

    // Both shifts come from the pre-update registers.
    assign x_sh = x_q >>> cnt_q;
    assign y_sh = y_q >>> cnt_q;

    // x is non-negative after pre-rotation, so its low 17 bits are the value.
    // Gain compensation: 1/2 + 1/16 + 1/32 + 1/64 - 1/512 ~= 0.60742.
    assign x_mag   = x_q[16:0];
    assign mag_sum = (x_mag >> 1) + (x_mag >> 4) + (x_mag >> 5)
                   + (x_mag >> 6) - (x_mag >> 9);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        angle_d = angle_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ITER;
                    cnt_d   = 4'd0;
                    zero_d  = (xin == 16'sd0) && (yin == 16'sd0);
                    // Pre-rotate into the right half-plane so the 16
                    // iterations (about +/-99.9 deg of reach) always converge.
                    if (!xin[15]) begin
                        x_d = xs_ext;
                        y_d = ys_ext;
                        z_d = 32'h0000_0000;
                    end else if (!yin[15]) begin
                        x_d = ys_ext;
                        y_d = -xs_ext;
                        z_d = 32'h4000_0000;
                    end else begin
                        x_d = -ys_ext;
                        y_d = xs_ext;
                        z_d = 32'hC000_0000;
                    end
                end
            end

            ITER: begin
                // Drive y toward zero; z accumulates the rotation applied.
                if (!y_q[17]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_lut(cnt_q);
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_lut(cnt_q);
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = COMP;
                end
            end

            COMP: begin
                if (zero_q) begin
                    mag_d   = 17'd0;
                    angle_d = 32'h0000_0000;
                end else begin
                    mag_d   = mag_sum;
                    angle_d = z_q;
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            x_q     <= 18'sd0;
            y_q     <= 18'sd0;
            z_q     <= 32'h0000_0000;
            zero_q  <= 1'b0;
            mag_q   <= 17'd0;
            angle_q <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            angle_q <= angle_d;
            valid_q <= valid_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign valid   = valid_q;
    assign mag     = mag_q;
    assign angle   = angle_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
module tb_cordic_vectoring;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] xin;
    logic signed [15:0] yin;
    logic               ready;
    logic               valid;
    logic        [16:0] mag;
    logic        [31:0] angle;
    logic        [1:0]  state_o;

    int n_vec  = 0;
    int n_miss = 0;

    cordic_vectoring dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .xin     (xin),
        .yin     (yin),
        .ready   (ready),
        .valid   (valid),
        .mag     (mag),
        .angle   (angle),
        .state_o (state_o)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- checkers ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Difference taken modulo 2^32, so it also serves wrapped angles.
    task automatic check_near(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp, input int tol);
        logic signed [31:0] d;
        logic               ok;
        d  = obs - exp;
        if (d < 0) d = -d;
        ok = (d <= tol);
        n_vec++;
        assert (ok === 1'b1)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h tol %0d", tag, obs, exp, tol);
        end
    endtask

    // Wait (bounded) for valid, counting edges; also check outputs hold meanwhile.
    task automatic wait_valid(input string tag, input int exp_lat);
        int          lat;
        logic [16:0] held_mag;
        logic [31:0] held_ang;
        lat      = 0;
        held_mag = mag;
        held_ang = angle;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            if (c == 8) begin
                check_eq({tag, " hold_mag"}, 32'(mag), 32'(held_mag));
                check_eq({tag, " hold_ang"}, angle, held_ang);
            end
            if (valid) begin
                lat = c;
                break;
            end
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // ---------------- driver ----------------
    task automatic run_vec(input string tag, input logic signed [15:0] x, input logic signed [15:0] y,
                           input int exp_mag, input logic [31:0] exp_ang, input int ang_tol);
        @(negedge clock);
        xin   = x;
        yin   = y;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        xin   = 16'($urandom);
        yin   = 16'($urandom);
        check_eq({tag, " ready_low"}, 32'(ready), 32'd0);
        wait_valid(tag, 17);
        check_near({tag, " mag"}, 32'(mag), 32'(exp_mag), (exp_mag / 1000) + 3);
        check_near({tag, " angle"}, angle, exp_ang, ang_tol);
        check_eq({tag, " ready_with_valid"}, 32'(ready), 32'd1);
        @(posedge clock); #1;
        check_eq({tag, " valid_one_cycle"}, 32'(valid), 32'd0);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock); #1;
            if (valid) seen++;
        end
        check_eq({tag, " no_valid"}, 32'(seen), 32'd0);
    endtask

    localparam int ATOL = 1 << 20;

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        start = 1'b1;
        xin   = 16'sd1234;
        yin   = -16'sd567;

        // Reset with start held high: reset wins.
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst ready", 32'(ready), 32'd1);
        check_eq("rst valid", 32'(valid), 32'd0);
        check_eq("rst mag", 32'(mag), 32'd0);
        check_eq("rst angle", angle, 32'd0);
        check_eq("rst state", 32'(state_o), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        watch_no_valid("post_rst", 25);

        // Axes
        run_vec("pos_x", 16'sd16384, 16'sd0, 16384, 32'h0000_0000, ATOL);
        run_vec("pos_y", 16'sd0, 16'sd16384, 16384, 32'h4000_0000, ATOL);
        run_vec("neg_x", -16'sd16384, 16'sd0, 16384, 32'h8000_0000, ATOL);
        run_vec("neg_y", 16'sd0, -16'sd16384, 16384, 32'hC000_0000, ATOL);

        // Diagonals and extremes
        run_vec("diag", 16'sd10000, 16'sd10000, 14142, 32'h2000_0000, ATOL);
        run_vec("extreme", -16'sd32768, -16'sd32768, 46341, 32'hA000_0000, ATOL);
        // atan2(-5000, 30000) = -9.4623 deg -> -0x06BA902D
        run_vec("q4", 16'sd30000, -16'sd5000, 30414, 32'hF945_6FD3, ATOL);

        // Zero vector: exact zeros, normal valid timing
        run_vec("zero", 16'sd0, 16'sd0, 0, 32'h0000_0000, 0);

        // Back-to-back with start held high and junk inputs while busy
        @(negedge clock);
        xin   = 16'sd0;
        yin   = 16'sd16384;
        start = 1'b1;
        @(posedge clock); #1;
        xin = 16'($urandom);
        yin = 16'($urandom);
        check_eq("b2b_a ready_low", 32'(ready), 32'd0);
        wait_valid("b2b_a", 17);
        check_near("b2b_a mag", 32'(mag), 32'd16384, 19);
        check_near("b2b_a angle", angle, 32'h4000_0000, ATOL);
        xin = -16'sd16384;
        yin = 16'sd0;
        @(posedge clock); #1;
        check_eq("b2b_b accepted", 32'(ready), 32'd0);
        xin = 16'($urandom);
        yin = 16'($urandom);
        wait_valid("b2b_b", 17);
        check_near("b2b_b mag", 32'(mag), 32'd16384, 19);
        check_near("b2b_b angle", angle, 32'h8000_0000, ATOL);
        start = 1'b0;
        @(posedge clock); #1;
        check_eq("b2b end ready", 32'(ready), 32'd1);
        check_eq("b2b end valid", 32'(valid), 32'd0);

        // Reset mid-run at iteration 8
        @(negedge clock);
        xin   = 16'sd10000;
        yin   = 16'sd10000;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("midrst ready", 32'(ready), 32'd1);
        check_eq("midrst valid", 32'(valid), 32'd0);
        check_eq("midrst mag", 32'(mag), 32'd0);
        check_eq("midrst angle", angle, 32'd0);
        check_eq("midrst state", 32'(state_o), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        watch_no_valid("midrst", 25);
        run_vec("after_rst", 16'sd10000, 16'sd10000, 14142, 32'h2000_0000, ATOL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
